// File: rtl/rob_commit_window_pkg.sv
// Shared sizing and the per-entry record for the in-order commit window.
// Widths here must agree with the tag, register and result widths of the EX writeback bundle.
package rob_commit_window_pkg;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int DATA_W = 32;
  localparam int PHY_W  = 6;
  localparam int ARCH_W = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [ARCH_W-1:0] rdst;
    logic [PHY_W-1:0]  phydst;
    logic [PHY_W-1:0]  oldphy;
    logic [DATA_W-1:0] result;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_window.sv
// 16-entry reorder window: tags at dispatch, completes on writeback, retires in order; WB->commit_valid 2 cycles.
// Backpressure: alloc_ready drops when the registered count is full; writebacks and commits are never stalled.
module rob_commit_window
  import rob_commit_window_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [ARCH_W-1:0] alloc_Rdst,
  input  logic [PHY_W-1:0]  alloc_Phydst,
  input  logic [PHY_W-1:0]  alloc_Oldphy,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_Commit_Window,
  input  logic              WB_valid,
  input  logic [IDX_W-1:0]  WB_Commit_Window,
  input  logic [PHY_W-1:0]  WB_Phydst,
  input  logic [ARCH_W-1:0] WB_Rdst,
  input  logic [DATA_W-1:0] WB_Result,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_Rdst,
  output logic [PHY_W-1:0]  commit_Phydst,
  output logic [PHY_W-1:0]  commit_Oldphy,
  output logic [DATA_W-1:0] commit_Result,
  output logic              empty
);

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [ARCH_W-1:0] commit_rdst_q, commit_rdst_d;
  logic [PHY_W-1:0]  commit_phydst_q, commit_phydst_d;
  logic [PHY_W-1:0]  commit_oldphy_q, commit_oldphy_d;
  logic [DATA_W-1:0] commit_result_q, commit_result_d;

  logic fire;
  logic alloc_fire;
  logic wb_hit;

  // The architectural destination on the writeback bundle is carried for debug only.
  logic unused_wb_rdst;
  assign unused_wb_rdst = ^WB_Rdst;

  assign alloc_ready         = (count_q != (IDX_W+1)'(DEPTH));
  assign alloc_Commit_Window = tail_q;
  assign empty               = (count_q == '0);

  assign commit_valid  = commit_valid_q;
  assign commit_Rdst   = commit_rdst_q;
  assign commit_Phydst = commit_phydst_q;
  assign commit_Oldphy = commit_oldphy_q;
  assign commit_Result = commit_result_q;

  always_comb begin
    entries_d       = entries_q;
    head_d          = head_q;
    tail_d          = tail_q;
    commit_valid_d  = 1'b0;
    commit_rdst_d   = commit_rdst_q;
    commit_phydst_d = commit_phydst_q;
    commit_oldphy_d = commit_oldphy_q;
    commit_result_d = commit_result_q;

    fire       = entries_q[head_q].valid && entries_q[head_q].done;
    alloc_fire = alloc_req && alloc_ready;
    // Phydst match rejects writebacks for squashed or already-reused tags.
    wb_hit     = WB_valid && entries_q[WB_Commit_Window].valid &&
                 (entries_q[WB_Commit_Window].phydst == WB_Phydst);

    if (wb_hit) begin
      entries_d[WB_Commit_Window].done   = 1'b1;
      entries_d[WB_Commit_Window].result = WB_Result;
    end

    if (fire) begin
      commit_valid_d              = 1'b1;
      commit_rdst_d               = entries_q[head_q].rdst;
      commit_phydst_d             = entries_q[head_q].phydst;
      commit_oldphy_d             = entries_q[head_q].oldphy;
      commit_result_d             = entries_q[head_q].result;
      entries_d[head_q].valid     = 1'b0;
      entries_d[head_q].done      = 1'b0;
      head_d                      = head_q + 1'b1;
    end

    // Tail never equals a live head here: that would mean full, and alloc is blocked when full.
    if (alloc_fire) begin
      entries_d[tail_q].valid  = 1'b1;
      entries_d[tail_q].done   = 1'b0;
      entries_d[tail_q].rdst   = alloc_Rdst;
      entries_d[tail_q].phydst = alloc_Phydst;
      entries_d[tail_q].oldphy = alloc_Oldphy;
      entries_d[tail_q].result = '0;
      tail_d                   = tail_q + 1'b1;
    end

    count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(fire);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_rdst_q   <= '0;
      commit_phydst_q <= '0;
      commit_oldphy_q <= '0;
      commit_result_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_rdst_q   <= commit_rdst_d;
      commit_phydst_q <= commit_phydst_d;
      commit_oldphy_q <= commit_oldphy_d;
      commit_result_q <= commit_result_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule
